// File: rtl/cmp_arbiter_pkg.sv
// Shared types for the round-robin compare arbiter: FSM state encoding and
// the three-flag comparison result.
package cmp_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic equal;
    logic a_more_b;
    logic a_less_b;
  } cmp_result_t;

  localparam cmp_result_t RESULT_NONE = '0;

endpackage

// File: rtl/cmp_arbiter_if.sv
// Request/response bundle for cmp_arbiter. Optional macro CMP_ARBITER_SIGNED_EN
// adds the per-requester req_signed select.
interface cmp_arbiter_if #(
  parameter int N    = 4,
  parameter int NREQ = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
`ifdef CMP_ARBITER_SIGNED_EN
  logic [NREQ-1:0]   req_signed;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic              rsp_equal;
  logic              rsp_a_more_b;
  logic              rsp_a_less_b;

  // master = requesters plus result consumer, slave = the arbiter
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
`ifdef CMP_ARBITER_SIGNED_EN
    output req_signed,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_equal, rsp_a_more_b, rsp_a_less_b
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
`ifdef CMP_ARBITER_SIGNED_EN
    input  req_signed,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_equal, rsp_a_more_b, rsp_a_less_b
  );

endinterface

// File: rtl/cmp_core.sv
// Purely combinational N-bit magnitude comparator. With CMP_ARBITER_SIGNED_EN
// the is_signed input selects two's-complement ordering.
module cmp_core
  import cmp_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef CMP_ARBITER_SIGNED_EN
  input  logic         is_signed,
`endif
  output cmp_result_t  result
);

  logic more;

  always_comb begin
`ifdef CMP_ARBITER_SIGNED_EN
    more = is_signed ? ($signed(a) > $signed(b)) : (a > b);
`else
    more = (a > b);
`endif
    result = RESULT_NONE;
    if (a == b) begin
      result.equal = 1'b1;
    end else if (more) begin
      result.a_more_b = 1'b1;
    end else begin
      result.a_less_b = 1'b1;
    end
  end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter feeding one shared comparator; result held in a
// single-entry output register. Optional macro: CMP_ARBITER_SIGNED_EN.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int N    = 4,
  parameter int NREQ = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cmp_arbiter_if.slave bus
);

  localparam int         ID_W    = $clog2(NREQ);
  localparam logic [0:0] ST_IDLE = 1'(IDLE);
  localparam logic [0:0] ST_HOLD = 1'(HOLD);

  logic [0:0]      state_reg, state_next;
  logic [ID_W-1:0] last_grant_reg;
  logic [ID_W-1:0] rsp_id_reg;
  cmp_result_t     result_reg;

  logic [NREQ-1:0] grant_onehot;
  logic [ID_W-1:0] grant_idx;
  logic            grant_any;
  logic            can_accept;
  logic            accept;
  logic [N-1:0]    op_a, op_b;
  cmp_result_t     cmp_result;

  // Search upward from last_grant+1 with wrap; only req_valid feeds this path.
  always_comb begin
    int idx;
    idx          = 0;
    grant_onehot = '0;
    grant_idx    = '0;
    grant_any    = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      idx = (int'(last_grant_reg) + off) % NREQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any         = 1'b1;
        grant_idx         = ID_W'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

  // rst_n gates acceptance so nothing is granted while reset is held
  assign can_accept    = rst_n & ((state_reg == ST_IDLE) | bus.rsp_ready);
  assign accept        = grant_any & can_accept;
  assign bus.req_ready = grant_onehot & {NREQ{can_accept}};

  assign op_a = bus.req_a[int'(grant_idx)*N +: N];
  assign op_b = bus.req_b[int'(grant_idx)*N +: N];

  cmp_core #(
    .N(N)
  ) u_cmp_core (
    .a         (op_a),
    .b         (op_b),
`ifdef CMP_ARBITER_SIGNED_EN
    .is_signed (bus.req_signed[grant_idx]),
`endif
    .result    (cmp_result)
  );

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      state_next = ST_HOLD;
    end else if ((state_reg == ST_HOLD) && bus.rsp_ready) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      result_reg     <= RESULT_NONE;
      rsp_id_reg     <= '0;
      last_grant_reg <= ID_W'(NREQ - 1);
    end else begin
      state_reg <= state_next;
      if (accept) begin
        result_reg     <= cmp_result;
        rsp_id_reg     <= grant_idx;
        last_grant_reg <= grant_idx;
      end else if ((state_reg == ST_HOLD) && bus.rsp_ready) begin
        // Drained with nothing new: flags go quiet while rsp_valid is low
        result_reg <= RESULT_NONE;
      end
    end
  end

  assign bus.rsp_valid    = (state_reg == ST_HOLD);
  assign bus.rsp_id       = rsp_id_reg;
  assign bus.rsp_equal    = result_reg.equal;
  assign bus.rsp_a_more_b = result_reg.a_more_b;
  assign bus.rsp_a_less_b = result_reg.a_less_b;

endmodule

// File: doc/cmp_arbiter.md
CMP_ARBITER -- requirements
Module: cmp_arbiter

Interface
REQ-001 Parameter N, default 4: operand width in bits, legal range 1..32.
REQ-002 Parameter NREQ, default 4: number of requesters, legal range 2..8.
REQ-003 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  NREQ  bit i high: requester i presents an operand pair.
REQ-007 req_a  input  NREQ*N  operand A; requester i occupies bits [i*N +: N].
REQ-008 req_b  input  NREQ*N  operand B; same packing as req_a.
REQ-009 req_ready  output  NREQ  one-hot or zero; bit i high: requester i is accepted this cycle.
REQ-010 rsp_valid  output  1  a comparison result is held.
REQ-011 rsp_ready  input  1  the consumer takes the result.
REQ-012 rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-013 rsp_equal, rsp_a_more_b, rsp_a_less_b  output  1 each  exactly one is high while rsp_valid is high.

Function
REQ-014 Handshakes SHALL be valid/ready: transfer happens when valid and ready are both high on a clock edge.
REQ-015 States SHALL be IDLE (no result held) and HOLD (result held, rsp_valid=1).
REQ-016 Round-robin grant SHALL go to the first requester with req_valid high, searching upward with wrap from index last_grant+1.
REQ-017 req_ready SHALL equal the one-hot grant when in IDLE, or when in HOLD with rsp_ready=1; otherwise req_ready SHALL be all zero.
REQ-018 On accept, the operands of the granted requester SHALL be compared through one shared comparator instance, and the result and rsp_id SHALL be registered, with latency 1 cycle from accept edge to rsp_valid.
REQ-019 Transitions SHALL be: IDLE to HOLD on accept; HOLD to IDLE on rsp_ready with no accept; HOLD to HOLD on rsp_ready with accept (back-to-back, no bubble); HOLD to HOLD on no rsp_ready, with outputs stable.
REQ-020 last_grant SHALL update only on an accept edge.
REQ-021 With no req_valid high, req_ready SHALL be 0 and no state change SHALL occur other than draining a held result.
REQ-022 Comparison SHALL be unsigned by default: A==B gives equal, A>B gives a_more_b, otherwise a_less_b.
REQ-023 req_ready SHALL NOT depend combinationally on req_a or req_b.

Reset
REQ-024 Asserting rst_n low SHALL force state to IDLE, rsp_valid to 0, rsp_id to 0, all result flags to 0, and last_grant to NREQ-1, so requester 0 has priority first.
REQ-025 Reset mid-transaction SHALL discard any held result, with no response emitted after reset release.
REQ-026 req_ready SHALL be 0 while rst_n is low.

Configuration
REQ-027 With macro CMP_ARBITER_SIGNED_EN defined, an input port req_signed (NREQ bits) SHALL be present, and the granted requester's bit SHALL select two's-complement comparison.
REQ-028 Without CMP_ARBITER_SIGNED_EN, the req_signed port SHALL be absent and all comparisons SHALL be unsigned.

Structure
REQ-029 The shared package cmp_arbiter_pkg SHALL hold the state enum (IDLE, HOLD) and a packed result struct {equal, a_more_b, a_less_b}.
REQ-030 Sub-module cmp_core SHALL be the purely combinational N-bit comparator (signed input under the macro), instantiated exactly once.

Verification
REQ-031 Reset release, req_valid=0001, A0=5, B0=5 -> req_ready=0001; next cycle rsp_valid=1, rsp_id=0, rsp_equal=1.
REQ-032 req_valid=1111 held constant, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_valid stays high with no bubble.
REQ-033 Result held with rsp_ready=0 for 3 cycles, req_valid=0010 -> req_ready=0000; rsp_* stable; grant 1 issued on the cycle rsp_ready rises.
REQ-034 A=4'hF, B=4'h1: unsigned -> rsp_a_more_b=1; with CMP_ARBITER_SIGNED_EN and req_signed=1 -> rsp_a_less_b=1.
REQ-035 rst_n pulsed low during HOLD -> rsp_valid=0 asynchronously; first grant after release goes to requester 0.
